// File: rtl/adam_pause_seq_pkg.sv
// Shared types and helpers for the pause sequencer.
package adam_pause_seq_pkg;

    // Sequencer states. RUN and PAUSED are the only states where slv_req is sampled.
    typedef enum logic [2:0] {
        ST_RUN,
        ST_PAUSE_TGT,
        ST_PAUSE_BUS,
        ST_PAUSED,
        ST_RESUME_BUS,
        ST_RESUME_TGT
    } state_t;

    // Wide enough to address the largest legal target count (32).
    localparam int IDX_W = 5;
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Step the target index one position in the requested direction.
    function automatic idx_t next_idx(input idx_t idx, input logic dir);
        return (dir == DIR_UP) ? idx + idx_t'(1) : idx - idx_t'(1);
    endfunction

endpackage

// File: rtl/adam_pause_seq.sv
// Sequences one upstream pause request across NO_TGTS targets and the bus.
// Pause order: targets ascending, then bus. Resume order: bus, then targets
// descending. Every step has a timeout that records unresponsive targets.
module adam_pause_seq
    import adam_pause_seq_pkg::*;
#(
    parameter int NO_TGTS   = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slv_req,
    output logic               slv_ack,
    output logic [NO_TGTS-1:0] tgt_req,
    input  logic [NO_TGTS-1:0] tgt_ack,
    output logic               bus_req,
    input  logic               bus_ack,
    output logic [NO_TGTS:0]   err,
    input  logic               err_clr
);

    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int             CW       = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam idx_t           IDX_LAST = idx_t'(NO_TGTS - 1);

    state_t             state, state_nxt;
    idx_t               idx, idx_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NO_TGTS-1:0] tgt_req_nxt;
    logic               bus_req_nxt;
    logic               slv_ack_nxt;
    logic [NO_TGTS:0]   err_nxt;
    logic               ack_cur;
    logic               timeout;

    // Select the ack of the target currently being stepped.
    always_comb begin
        ack_cur = 1'b0;
        for (int i = 0; i < NO_TGTS; i++) begin
            if (idx == idx_t'(i)) ack_cur = tgt_ack[i];
        end
    end

    assign timeout = TO_EN && (cnt == CNT_LAST);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        tgt_req_nxt = tgt_req;
        bus_req_nxt = bus_req;
        slv_ack_nxt = slv_ack;
        // Clear first so that a timeout set later in this block wins.
        err_nxt     = err_clr ? '0 : err;

        unique case (state)
            ST_RUN: begin
                if (slv_req) begin
                    state_nxt      = ST_PAUSE_TGT;
                    idx_nxt        = '0;
                    cnt_nxt        = '0;
                    tgt_req_nxt[0] = 1'b1;
                end
            end

            ST_PAUSE_TGT: begin
                if (ack_cur || timeout) begin
                    cnt_nxt = '0;
                    for (int i = 0; i < NO_TGTS; i++) begin
                        if (!ack_cur && idx == idx_t'(i)) err_nxt[i] = 1'b1;
                    end
                    if (idx < IDX_LAST) begin
                        idx_nxt = next_idx(idx, DIR_UP);
                        for (int i = 0; i < NO_TGTS; i++) begin
                            if (idx_nxt == idx_t'(i)) tgt_req_nxt[i] = 1'b1;
                        end
                    end else begin
                        state_nxt   = ST_PAUSE_BUS;
                        bus_req_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_PAUSE_BUS: begin
                if (bus_ack || timeout) begin
                    if (!bus_ack) err_nxt[NO_TGTS] = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_PAUSED;
                    slv_ack_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_PAUSED: begin
                if (!slv_req) begin
                    state_nxt   = ST_RESUME_BUS;
                    cnt_nxt     = '0;
                    bus_req_nxt = 1'b0;
                end
            end

            ST_RESUME_BUS: begin
                if (!bus_ack || timeout) begin
                    if (bus_ack) err_nxt[NO_TGTS] = 1'b1;
                    cnt_nxt                  = '0;
                    state_nxt                = ST_RESUME_TGT;
                    idx_nxt                  = IDX_LAST;
                    tgt_req_nxt[NO_TGTS-1]   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_RESUME_TGT: begin
                if (!ack_cur || timeout) begin
                    cnt_nxt = '0;
                    for (int i = 0; i < NO_TGTS; i++) begin
                        if (ack_cur && idx == idx_t'(i)) err_nxt[i] = 1'b1;
                    end
                    if (idx != '0) begin
                        idx_nxt = next_idx(idx, DIR_DOWN);
                        for (int i = 0; i < NO_TGTS; i++) begin
                            if (idx_nxt == idx_t'(i)) tgt_req_nxt[i] = 1'b0;
                        end
                    end else begin
                        state_nxt   = ST_RUN;
                        slv_ack_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = ST_PAUSED;
            end
        endcase
    end

    // State and output registers; reset boots the system fully paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_PAUSED;
            idx     <= '0;
            cnt     <= '0;
            tgt_req <= '1;
            bus_req <= 1'b1;
            slv_ack <= 1'b1;
            err     <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            tgt_req <= tgt_req_nxt;
            bus_req <= bus_req_nxt;
            slv_ack <= slv_ack_nxt;
            err     <= err_nxt;
        end
    end

endmodule
